decode_writeback: RTL and testbench

DECODE_WRITEBACK -- requirements
Module: decode_writeback

---
 rtl/y86_pkg.sv | 21 ++
 rtl/regfile_15x64.sv | 39 +++
 rtl/decode_writeback.sv | 84 ++++++++
 tb/tb_decode_writeback.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, special register IDs, word width.
package y86_pkg;
  localparam int WORD_W = 64;
  localparam int NREGS  = 15;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;
endpackage

// File: rtl/regfile_15x64.sv
// 15 x 64-bit register file: two combinational read ports, two write ports.
// ID F is a null register: reads as zero, writes are dropped.
module regfile_15x64
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        raddr_a,
  input  logic [3:0]        raddr_b,
  output logic [WORD_W-1:0] rdata_a,
  output logic [WORD_W-1:0] rdata_b,
  input  logic              we_e,
  input  logic [3:0]        waddr_e,
  input  logic [WORD_W-1:0] wdata_e,
  input  logic              we_m,
  input  logic [3:0]        waddr_m,
  input  logic [WORD_W-1:0] wdata_m
);
  logic [WORD_W-1:0] regs_q [NREGS];
  logic [WORD_W-1:0] regs_d [NREGS];

  // M port applied last so it wins a same-address collision (popq %rsp).
  always_comb begin
    regs_d = regs_q;
    if (we_e && waddr_e != RNONE) regs_d[waddr_e] = wdata_e;
    if (we_m && waddr_m != RNONE) regs_d[waddr_m] = wdata_m;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a = (raddr_a == RNONE) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == RNONE) ? '0 : regs_q[raddr_b];
endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode/write-back: combinational source/destination ID selection
// feeding a 15-entry register file.
module decode_writeback
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              Cnd,
  input  logic [WORD_W-1:0] valE,
  input  logic [WORD_W-1:0] valM,
  input  logic              wb_en,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [WORD_W-1:0] valA,
  output logic [WORD_W-1:0] valB
);
  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      IRRMOVQ: begin
        srcA = rA;
        dstE = Cnd ? rB : RNONE;
      end
      IIRMOVQ: dstE = rB;
      IRMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      IMRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      IOPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      ICALL: begin
        srcB = RRSP;
        dstE = RRSP;
      end
      IRET: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
      end
      IPUSHQ: begin
        srcA = rA;
        srcB = RRSP;
        dstE = RRSP;
      end
      IPOPQ: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  regfile_15x64 u_rf (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (srcA),
    .raddr_b (srcB),
    .rdata_a (valA),
    .rdata_b (valB),
    .we_e    (wb_en),
    .waddr_e (dstE),
    .wdata_e (valE),
    .we_m    (wb_en),
    .waddr_m (dstM),
    .wdata_m (valM)
  );
endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: ID-selection table plus write-back sequences.
module tb_decode_writeback;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  icode, rA, rB;
  logic        Cnd;
  logic [63:0] valE, valM;
  logic        wb_en;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB;

  int total = 0;
  int bad   = 0;

  decode_writeback dut (
    .clk(clk), .reset(reset), .icode(icode), .rA(rA), .rB(rB), .Cnd(Cnd),
    .valE(valE), .valM(valM), .wb_en(wb_en),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valA(valA), .valB(valB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] icode, rA, rB;
    logic       cnd;
    logic [3:0] e_srcA, e_srcB, e_dstE, e_dstM;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] r, output logic [63:0] v);
    icode = 4'h6; rA = r; rB = 4'hF; Cnd = 1'b0; wb_en = 1'b0;
    #1;
    v = valA;
  endtask

  task automatic wr(input logic [3:0] r, input logic [63:0] v);
    icode = 4'h3; rA = 4'hF; rB = r; valE = v; valM = '0; wb_en = 1'b1;
    step();
    wb_en = 1'b0;
  endtask

  initial begin
    logic [63:0] v;
    //            icode  rA     rB     cnd   srcA   srcB   dstE   dstM
    vecs[0]  = '{4'h0, 4'h1, 4'h2, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[1]  = '{4'h1, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[2]  = '{4'h2, 4'h1, 4'h2, 1'b1, 4'h1, 4'hF, 4'h2, 4'hF};
    vecs[3]  = '{4'h2, 4'h1, 4'h2, 1'b0, 4'h1, 4'hF, 4'hF, 4'hF};
    vecs[4]  = '{4'h3, 4'hF, 4'h5, 1'b0, 4'hF, 4'hF, 4'h5, 4'hF};
    vecs[5]  = '{4'h4, 4'h3, 4'h6, 1'b0, 4'h3, 4'h6, 4'hF, 4'hF};
    vecs[6]  = '{4'h5, 4'h7, 4'h8, 1'b0, 4'hF, 4'h8, 4'hF, 4'h7};
    vecs[7]  = '{4'h6, 4'h2, 4'h3, 1'b0, 4'h2, 4'h3, 4'h3, 4'hF};
    vecs[8]  = '{4'h7, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[9]  = '{4'h8, 4'h1, 4'h2, 1'b0, 4'hF, 4'h4, 4'h4, 4'hF};
    vecs[10] = '{4'h9, 4'h1, 4'h2, 1'b0, 4'h4, 4'h4, 4'h4, 4'hF};
    vecs[11] = '{4'hA, 4'h5, 4'h2, 1'b0, 4'h5, 4'h4, 4'h4, 4'hF};
    vecs[12] = '{4'hB, 4'h6, 4'h2, 1'b0, 4'h4, 4'h4, 4'h4, 4'h6};
    vecs[13] = '{4'hC, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[14] = '{4'hF, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};

    icode = 4'h6; rA = 4'h2; rB = 4'h3; Cnd = 1'b0;
    valE = 64'h9; valM = 64'h8; wb_en = 1'b1; reset = 1'b1;
    step();
    step();
    // reset held, write attempt suppressed; IDs still combinational
    chk("reset_srcA", {60'd0, srcA}, 64'h2);
    chk("reset_srcB", {60'd0, srcB}, 64'h3);
    chk("reset_dstE", {60'd0, dstE}, 64'h3);
    chk("reset_dstM", {60'd0, dstM}, 64'hF);
    chk("reset_valA", valA, 64'h0);
    chk("reset_valB", valB, 64'h0);
    reset = 1'b0; wb_en = 1'b0;
    for (int r = 0; r < 15; r++) begin
      rd(r[3:0], v);
      chk($sformatf("reset_reg%0d", r), v, 64'h0);
    end

    for (int i = 0; i < 15; i++) begin
      icode = vecs[i].icode; rA = vecs[i].rA; rB = vecs[i].rB; Cnd = vecs[i].cnd;
      #1;
      chk($sformatf("ids_vec%0d", i), {48'd0, srcA, srcB, dstE, dstM},
          {48'd0, vecs[i].e_srcA, vecs[i].e_srcB, vecs[i].e_dstE, vecs[i].e_dstM});
    end

    // irmovq then read back; then opq on same reg shows no bypass
    wr(4'h1, 64'h1234);
    rd(4'h1, v);
    chk("irmovq_reg1", v, 64'h1234);
    icode = 4'h6; rA = 4'h1; rB = 4'h1; valE = 64'h55; wb_en = 1'b1;
    #1;
    chk("no_bypass_before", valA, 64'h1234);
    step();
    wb_en = 1'b0;
    chk("opq_after_edge", valA, 64'h55);

    // cmov not taken / taken
    wr(4'h5, 64'h99);
    icode = 4'h2; rA = 4'h0; rB = 4'h5; Cnd = 1'b0; valE = 64'h7; wb_en = 1'b1;
    #1;
    chk("cmov_nt_dstE", {60'd0, dstE}, 64'hF);
    step();
    rd(4'h5, v);
    chk("cmov_nt_reg5", v, 64'h99);
    icode = 4'h2; rA = 4'h0; rB = 4'h5; Cnd = 1'b1; valE = 64'h7; wb_en = 1'b1;
    step();
    rd(4'h5, v);
    chk("cmov_t_reg5", v, 64'h7);

    // popq %rsp: M wins over E
    icode = 4'hB; rA = 4'h4; rB = 4'hF; valE = 64'h10; valM = 64'hAA; wb_en = 1'b1;
    #1;
    chk("popq_dstE", {60'd0, dstE}, 64'h4);
    chk("popq_dstM", {60'd0, dstM}, 64'h4);
    step();
    rd(4'h4, v);
    chk("popq_rsp_reg4", v, 64'hAA);

    // popq %rbx: both ports write distinct regs
    icode = 4'hB; rA = 4'h3; valE = 64'h20; valM = 64'hBB; wb_en = 1'b1;
    step();
    rd(4'h4, v);
    chk("popq_rbx_reg4", v, 64'h20);
    rd(4'h3, v);
    chk("popq_rbx_reg3", v, 64'hBB);

    // unknown icode with wb_en=1 writes nothing
    icode = 4'hC; rA = 4'h3; rB = 4'h3; valE = 64'hDEAD; valM = 64'hBEEF; wb_en = 1'b1;
    step();
    rd(4'h3, v);
    chk("unknown_no_write", v, 64'hBB);

    // reset overrides same-edge write
    wr(4'h2, 64'h5);
    rd(4'h2, v);
    chk("pre_reset_reg2", v, 64'h5);
    icode = 4'h3; rA = 4'hF; rB = 4'h2; valE = 64'h9; wb_en = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; wb_en = 1'b0;
    rd(4'h2, v);
    chk("reset_over_write", v, 64'h0);

    // pushq with rA=F and wb_en=0: nothing changes over several edges
    wr(4'h4, 64'h44);
    wr(4'h7, 64'h77);
    icode = 4'hA; rA = 4'hF; rB = 4'hF; valE = 64'h1; valM = 64'h2; wb_en = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("push_srcA", {60'd0, srcA}, 64'hF);
    chk("push_valA", valA, 64'h0);
    chk("push_srcB", {60'd0, srcB}, 64'h4);
    chk("push_valB", valB, 64'h44);
    rd(4'h4, v);
    chk("noen_reg4", v, 64'h44);
    rd(4'h7, v);
    chk("noen_reg7", v, 64'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
